// File: rtl/mode_switch_controller.sv
// Mode switch controller: button-driven mode selection committed to the datapath
// once bus traffic has been idle. Optional LED blink: MODE_PENDING_BLINK_EN.
`timescale 1ns/1ps

module mode_switch_controller #(
    parameter int MODE_WIDTH         = 4,
    parameter int NUM_MODES          = 10,
    parameter int IDLE_CYCLES        = 16,
    parameter int ACK_TIMEOUT_CYCLES = 255,
    parameter int BLINK_HALF_PERIOD  = 6_000_000
) (
    input  logic                  sys_clk,
    input  logic                  rst_n,
    input  logic                  mode_btn,
    input  logic                  comm_active,
    input  logic                  mode_change_ack,
    output logic                  mode_change_req,
    output logic [MODE_WIDTH-1:0] target_mode,
    output logic [MODE_WIDTH-1:0] active_mode,
    output logic                  pending,
    output logic                  commit_timeout,
    output logic [MODE_WIDTH-1:0] mode_leds
);

    localparam int IW = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
    localparam int AW = (ACK_TIMEOUT_CYCLES > 1) ? $clog2(ACK_TIMEOUT_CYCLES) : 1;
    localparam logic [MODE_WIDTH-1:0] LAST_MODE = MODE_WIDTH'(NUM_MODES - 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_CYCLES - 1);
    localparam logic [AW-1:0] ACK_LAST = AW'(ACK_TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PENDING,
        S_COMMIT
    } state_t;

    state_t                  state, state_nxt;
    logic                    btn_prev;
    logic                    press;
    logic [MODE_WIDTH-1:0]   target_nxt, active_nxt;
    logic [IW-1:0]           idle_cnt, idle_nxt;
    logic [AW-1:0]           ack_cnt, ack_nxt;
    logic                    timeout_nxt;

    function automatic logic [MODE_WIDTH-1:0] next_mode(input logic [MODE_WIDTH-1:0] m);
        return (m == LAST_MODE) ? '0 : m + 1'b1;
    endfunction

    assign press           = mode_btn & ~btn_prev;
    assign pending         = (state != S_IDLE);
    assign mode_change_req = (state == S_COMMIT);

    // State and datapath registers; btn_prev resets high so a held button is not a press
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            btn_prev       <= 1'b1;
            target_mode    <= '0;
            active_mode    <= '0;
            idle_cnt       <= '0;
            ack_cnt        <= '0;
            commit_timeout <= 1'b0;
        end else begin
            state          <= state_nxt;
            btn_prev       <= mode_btn;
            target_mode    <= target_nxt;
            active_mode    <= active_nxt;
            idle_cnt       <= idle_nxt;
            ack_cnt        <= ack_nxt;
            commit_timeout <= timeout_nxt;
        end
    end

    // Next-state logic: presses win over the idle-count commit; COMMIT ignores presses
    always_comb begin
        state_nxt   = state;
        target_nxt  = target_mode;
        active_nxt  = active_mode;
        idle_nxt    = idle_cnt;
        ack_nxt     = ack_cnt;
        timeout_nxt = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (press) begin
                    target_nxt = next_mode(active_mode);
                    idle_nxt   = '0;
                    state_nxt  = S_PENDING;
                end
            end
            S_PENDING: begin
                if (press) begin
                    target_nxt = next_mode(target_mode);
                    idle_nxt   = '0;
                end else if (comm_active) begin
                    idle_nxt = '0;
                end else if (idle_cnt == IDLE_LAST) begin
                    idle_nxt  = '0;
                    ack_nxt   = '0;
                    state_nxt = S_COMMIT;
                end else begin
                    idle_nxt = idle_cnt + 1'b1;
                end
            end
            S_COMMIT: begin
                if (mode_change_ack) begin
                    active_nxt = target_mode;
                    ack_nxt    = '0;
                    state_nxt  = S_IDLE;
                end else if (ack_cnt == ACK_LAST) begin
                    timeout_nxt = 1'b1;
                    ack_nxt     = '0;
                    state_nxt   = S_IDLE;
                end else begin
                    ack_nxt = ack_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

`ifdef MODE_PENDING_BLINK_EN
    localparam int BW = (BLINK_HALF_PERIOD > 1) ? $clog2(BLINK_HALF_PERIOD) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF_PERIOD - 1);

    logic [BW-1:0] blink_cnt;
    logic          blink_on;
    logic          blink_restart;

    assign blink_restart = press & (state != S_COMMIT);

    // Blink timer: restarts on any accepted press, showing target_mode first
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (blink_restart || !pending) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= '0;
            blink_on  <= ~blink_on;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    assign mode_leds = pending ? (blink_on ? target_mode : '0) : active_mode;
`else
    logic unused_blink_cfg;

    assign unused_blink_cfg = (BLINK_HALF_PERIOD > 0);
    assign mode_leds        = active_mode;
`endif

endmodule
